// File: rtl/exu_cal_arb_pkg.sv
// Shared types and constants for the execute-stage cal unit arbiter.
package exu_cal_arb_pkg;

  // Width of the common cal op-bundle.
  localparam int CAL_OPB_SIZE = 40;

  // Requester slots on the request vector.
  localparam int ARB_ALU = 0;
  localparam int ARB_BJU = 1;
  localparam int ARB_LSU = 2;
  localparam int ARB_MDU = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/exu_cal_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N. Outputs are all-zero when no request is set.
module exu_cal_arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [PW-1:0] gnt_idx_o
);

  // One extra bit so ptr + offset (< 2N) never overflows before the wrap.
  localparam int SW = PW + 1;

  // Scan slots in priority order starting at the pointer; first hit wins.
  always_comb begin
    logic [SW-1:0] slot;
    logic          found;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    slot      = '0;
    for (int i = 0; i < N; i++) begin
      slot = {1'b0, ptr_i} + SW'(i);
      if (slot >= SW'(N)) slot = slot - SW'(N);
      if (!found && req_i[slot[PW-1:0]]) begin
        found                     = 1'b1;
        gnt_oh_o[slot[PW-1:0]]    = 1'b1;
        gnt_idx_o                 = slot[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/exu_cal_arb.sv
// Round-robin arbiter/sequencer in front of the shared cal unit.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a request; picks a winner and latches its opb
//   BUSY  | opb driven to the cal unit until it reports done
//   RESP  | result held in o_res, one-cycle rdy pulse to the winner
module exu_cal_arb
  import exu_cal_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int OPB_W = CAL_OPB_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic [N-1:0]       hs_req4arb_val,
  input  logic [N*OPB_W-1:0] i_req_opb,
  output logic [N-1:0]       hs_arb4req_rdy,
  output logic [31:0]        o_res,
  output logic               hs_arb4cal_val,
  output logic [OPB_W-1:0]   o_cal_opb,
  input  logic               i_cal_done,
  input  logic [31:0]        i_cal_res,
  output logic               o_busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_e         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      gnt_q, gnt_d;
  logic [N-1:0]       gnt_oh_q, gnt_oh_d;
  logic [OPB_W-1:0]   opb_q, opb_d;
  logic [31:0]        res_q, res_d;

  logic [N-1:0]       pick_oh;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      ptr_after_gnt;
  logic [OPB_W-1:0]   req_opb [N];

  for (genvar k = 0; k < N; k++) begin : g_opb_slice
    assign req_opb[k] = i_req_opb[k*OPB_W +: OPB_W];
  end

  exu_cal_arb_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req_i     (hs_req4arb_val),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx)
  );

  assign ptr_after_gnt = (gnt_q == PW'(N - 1)) ? '0 : gnt_q + PW'(1);

  // Next-state and hold-register updates; flush always returns to IDLE
  // and leaves the round-robin pointer untouched.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_oh_d = gnt_oh_q;
    opb_d    = opb_q;
    res_d    = res_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (!i_flush && (|hs_req4arb_val)) begin
          state_d  = ARB_BUSY;
          gnt_d    = pick_idx;
          gnt_oh_d = pick_oh;
          opb_d    = req_opb[pick_idx];
        end
      end
      ARB_BUSY: begin
        if (i_flush) begin
          state_d = ARB_IDLE;
        end else if (i_cal_done) begin
          res_d   = i_cal_res;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        // The rdy pulse is already on the wire this cycle; a flush here
        // only suppresses the pointer advance.
        state_d = ARB_IDLE;
        if (!i_flush) ptr_d = ptr_after_gnt;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, pointer and hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      opb_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
    end
  end

  // All outputs decode from registered state only, so none of them has a
  // combinational path from the requester or cal unit inputs.
  assign hs_arb4cal_val = (state_q == ARB_BUSY);
  assign o_cal_opb      = hs_arb4cal_val ? opb_q : '0;
  assign hs_arb4req_rdy = (state_q == ARB_RESP) ? gnt_oh_q : '0;
  assign o_res          = res_q;
  assign o_busy         = (state_q != ARB_IDLE);

endmodule
